present80_dec_round: RTL and testbench

- Round-based, area-optimised PRESENT-80 decryption core; the inverse of the round-based encryption datapath.
- Takes a 64-bit ciphertext and an 80-bit user key, and produces the 64-bit plaintext.
- One round per clock; a single 80-bit key register and a single 64-bit state register are reused.
- Sits beside the encryption core behind the same start/done handshake. Shares the 80-bit 2:1 load muxing style on key and state inputs.

---
 rtl/present80_dec_round_pkg.sv | 38 +++
 rtl/present_inv_sbox4.sv | 11 +
 rtl/present80_dec_round.sv | 180 ++++++++++++++++++
 tb/tb_present80_dec_round.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/present80_dec_round_pkg.sv
// PRESENT-80 shared constants, FSM state type and bit-layer helpers for the round-based decryption core.
package present_pkg;

   localparam int unsigned STATE_W = 64;
   localparam int unsigned KEY_W   = 80;
   localparam int unsigned NIB_W   = 4;
   localparam int unsigned NUM_NIB = STATE_W / NIB_W;

   localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   localparam logic [3:0] INV_SBOX [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                            4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

   typedef enum logic [1:0] {
      IDLE,
      KEYGEN,
      ROUND,
      FINAL
   } state_e;

   // Forward S-box, only needed on the top key nibble during key generation.
   function automatic logic [3:0] sbox4(input logic [3:0] x);
      return SBOX[x];
   endfunction

   // Inverse bit permutation: output bit i takes the bit that P moved from i, P(i) = 16*i mod 63.
   function automatic logic [STATE_W-1:0] inv_perm(input logic [STATE_W-1:0] x);
      logic [STATE_W-1:0] y;
      y = '0;
      for (int unsigned i = 0; i < STATE_W - 1; i++) begin
         y[6'(i)] = x[6'((16 * i) % (STATE_W - 1))];
      end
      y[STATE_W-1] = x[STATE_W-1];
      return y;
   endfunction

endpackage

// File: rtl/present_inv_sbox4.sv
// 4-bit PRESENT inverse S-box, purely combinational.
module present_inv_sbox4
   import present_pkg::*;
(
   input  logic [3:0] x_i,
   output logic [3:0] y_c_o
);

   assign y_c_o = INV_SBOX[x_i];

endmodule

// File: rtl/present80_dec_round.sv
// Round-based PRESENT-80 decryption: runs the forward key schedule up to K32, then one inverse round per clock.
// Defining PRESENT_DEC_KEY_CACHE_EN adds a one-entry K32 cache that skips key generation on a repeated key.
module present80_dec_round
   import present_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 31,
   parameter int unsigned CNT_W      = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [KEY_W-1:0]   key,
   input  logic [STATE_W-1:0] ctext,
   output logic [STATE_W-1:0] ptext,
   output logic               busy,
   output logic               done
);

   localparam int unsigned      RC_W     = 5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ROUNDS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e             fsm_q, fsm_d;
   logic [STATE_W-1:0] state_q, state_d;
   logic [STATE_W-1:0] ptext_q, ptext_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [RC_W-1:0]    rc_c;
   logic [KEY_W-1:0]   fwd_rot_c, fwd_key_c, inv_xor_c, inv_key_c;
   logic [3:0]         inv_top_c;
   logic [STATE_W-1:0] perm_c, round_c;

`ifdef PRESENT_DEC_KEY_CACHE_EN
   logic [KEY_W-1:0]   last_key_q, last_key_d;
   logic [KEY_W-1:0]   k32_q, k32_d;
   logic               cache_vld_q, cache_vld_d;
   logic               cache_hit_c;

   assign cache_hit_c = cache_vld_q && (key == last_key_q);
`endif

   assign rc_c = RC_W'(cnt_q);

   // Forward key step: rotate left 61, S on the top nibble, fold in the round counter.
   always_comb begin
      fwd_rot_c        = {key_q[18:0], key_q[79:19]};
      fwd_key_c        = fwd_rot_c;
      fwd_key_c[79:76] = sbox4(fwd_rot_c[79:76]);
      fwd_key_c[19:15] = fwd_rot_c[19:15] ^ rc_c;
   end

   // Inverse key step: undo the counter, InvS on the top nibble, then rotate right 61.
   always_comb begin
      inv_xor_c        = key_q;
      inv_xor_c[19:15] = key_q[19:15] ^ rc_c;
   end

   present_inv_sbox4 u_key_isb (
      .x_i   (inv_xor_c[79:76]),
      .y_c_o (inv_top_c)
   );

   assign inv_key_c = {inv_xor_c[60:0], inv_top_c, inv_xor_c[75:61]};

   assign perm_c = inv_perm(state_q ^ key_q[79:16]);

   for (genvar n = 0; n < NUM_NIB; n++) begin : g_state_isb
      present_inv_sbox4 u_isb (
         .x_i   (perm_c[NIB_W*n +: NIB_W]),
         .y_c_o (round_c[NIB_W*n +: NIB_W])
      );
   end

   // Next-state and datapath control.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      cnt_d   = cnt_q;
      ptext_d = ptext_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
      last_key_d  = last_key_q;
      k32_d       = k32_q;
      cache_vld_d = cache_vld_q;
`endif
      case (fsm_q)
         IDLE: begin
            if (start) begin
               state_d = ctext;
               busy_d  = 1'b1;
`ifdef PRESENT_DEC_KEY_CACHE_EN
               if (cache_hit_c) begin
                  key_d = k32_q;
                  cnt_d = CNT_LAST;
                  fsm_d = ROUND;
               end else begin
                  key_d       = key;
                  cnt_d       = CNT_ONE;
                  fsm_d       = KEYGEN;
                  last_key_d  = key;
                  cache_vld_d = 1'b0;
               end
`else
               key_d = key;
               cnt_d = CNT_ONE;
               fsm_d = KEYGEN;
`endif
            end
         end
         KEYGEN: begin
            key_d = fwd_key_c;
            if (cnt_q == CNT_LAST) begin
               fsm_d = ROUND;
`ifdef PRESENT_DEC_KEY_CACHE_EN
               k32_d       = fwd_key_c;
               cache_vld_d = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ROUND: begin
            state_d = round_c;
            key_d   = inv_key_c;
            if (cnt_q == CNT_ONE) begin
               fsm_d = FINAL;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         FINAL: begin
            ptext_d = state_q ^ key_q[79:16];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            fsm_d   = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         key_q   <= '0;
         cnt_q   <= '0;
         ptext_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef PRESENT_DEC_KEY_CACHE_EN
         last_key_q  <= '0;
         k32_q       <= '0;
         cache_vld_q <= 1'b0;
`endif
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         cnt_q   <= cnt_d;
         ptext_q <= ptext_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef PRESENT_DEC_KEY_CACHE_EN
         last_key_q  <= last_key_d;
         k32_q       <= k32_d;
         cache_vld_q <= cache_vld_d;
`endif
      end
   end

   assign ptext = ptext_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_present80_dec_round.sv
// Bench for present80_dec_round: known-answer vectors plus random plaintexts encrypted by a forward PRESENT-80 model.
module tb_present80_dec_round;

   localparam int MAX_WAIT = 200;
`ifdef PRESENT_DEC_KEY_CACHE_EN
   localparam bit CACHE_EN = 1'b1;
`else
   localparam bit CACHE_EN = 1'b0;
`endif

   localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   localparam logic [79:0] VEC_KEY [4] = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
   localparam logic [63:0] VEC_CT  [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                                           64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
   localparam logic [63:0] VEC_PT  [4] = '{64'h0, 64'h0, {64{1'b1}}, {64{1'b1}}};

   logic        clk, rst, start;
   logic [79:0] key;
   logic [63:0] ctext, ptext;
   logic        busy, done;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          cache_vld = 1'b0;
   logic [79:0] cache_key = '0;

   present80_dec_round dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .key   (key),
      .ctext (ctext),
      .ptext (ptext),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached without finishing");
      $fatal(1, "time limit");
   end

   // Forward PRESENT-80 encryption, the reference the decryptor must invert.
   function automatic logic [63:0] model_encrypt(input logic [63:0] pt, input logic [79:0] k);
      logic [79:0] kr;
      logic [63:0] s, t;
      kr = k;
      s  = pt;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ kr[79:16];
         for (int n = 0; n < 16; n++) t[n*4 +: 4] = SB[s[n*4 +: 4]];
         for (int i = 0; i < 63; i++) s[6'((16 * i) % 63)] = t[6'(i)];
         s[63] = t[63];
         kr = {kr[18:0], kr[79:19]};
         kr[79:76] = SB[kr[79:76]];
         kr[19:15] = kr[19:15] ^ 5'(r);
      end
      return s ^ kr[79:16];
   endfunction

   task automatic run_op(input logic [79:0] k, input logic [63:0] ct, output logic [63:0] pt,
                         output int lat, output int exp_lat, output int busy_bad);
      exp_lat = (CACHE_EN && cache_vld && (k == cache_key)) ? 32 : 63;
      @(negedge clk);
      key   = k;
      ctext = ct;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      key   = 80'({$urandom(), $urandom(), $urandom()});
      ctext = {$urandom(), $urandom()};
      lat      = -1;
      pt       = 'x;
      busy_bad = 0;
      for (int c = 0; c < MAX_WAIT; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            pt  = ptext;
            if (busy) busy_bad++;
            break;
         end
         if (!busy) busy_bad++;
      end
      cache_vld = 1'b1;
      cache_key = k;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; key = '0; ctext = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (ptext !== 64'h0) begin n_fail++; $display("FAIL reset_ptext: got %h want %h", ptext, 64'h0); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_known_vectors();
      logic [63:0] pt;
      int lat, el, bb;
      for (int i = 0; i < 4; i++) begin
         run_op(VEC_KEY[i], VEC_CT[i], pt, lat, el, bb);
         n_checks++;
         if (pt !== VEC_PT[i]) begin n_fail++; $display("FAIL kat%0d_ptext: got %h want %h", i, pt, VEC_PT[i]); end
         n_checks++;
         if (lat != el) begin n_fail++; $display("FAIL kat%0d_latency: got %0d want %0d", i, lat, el); end
         n_checks++;
         if (bb != 0) begin n_fail++; $display("FAIL kat%0d_busy: got %0d bad cycles want 0", i, bb); end
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0) begin n_fail++; $display("FAIL kat%0d_done_pulse: got %b want 0", i, done); end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] pt;
      int lat, el, bb;
      for (int i = 2; i < 4; i++) begin
         run_op(VEC_KEY[i], VEC_CT[i], pt, lat, el, bb);
         n_checks++;
         if (pt !== VEC_PT[i]) begin n_fail++; $display("FAIL b2b%0d_ptext: got %h want %h", i, pt, VEC_PT[i]); end
         n_checks++;
         if (lat != el) begin n_fail++; $display("FAIL b2b%0d_latency: got %0d want %0d", i, lat, el); end
      end
   endtask

   task automatic test_key_cache();
      logic [63:0] pt;
      int lat, el, bb;
      int seq [3] = '{0, 0, 1};
      for (int j = 0; j < 3; j++) begin
         run_op(VEC_KEY[seq[j]], VEC_CT[seq[j]], pt, lat, el, bb);
         n_checks++;
         if (pt !== VEC_PT[seq[j]]) begin
            n_fail++; $display("FAIL cache%0d_ptext: got %h want %h", j, pt, VEC_PT[seq[j]]);
         end
         n_checks++;
         if (lat != el) begin n_fail++; $display("FAIL cache%0d_latency: got %0d want %0d", j, lat, el); end
      end
   endtask

   task automatic test_random();
      logic [63:0] pt, ref_pt;
      logic [79:0] k;
      int lat, el, bb;
      k = '0;
      for (int i = 0; i < 8; i++) begin
         if (i != 3) k = 80'({$urandom(), $urandom(), $urandom()});
         ref_pt = {$urandom(), $urandom()};
         run_op(k, model_encrypt(ref_pt, k), pt, lat, el, bb);
         n_checks++;
         if (pt !== ref_pt) begin n_fail++; $display("FAIL rand%0d_ptext: got %h want %h", i, pt, ref_pt); end
         n_checks++;
         if (lat != el) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, el); end
         n_checks++;
         if (bb != 0) begin n_fail++; $display("FAIL rand%0d_busy: got %0d bad cycles want 0", i, bb); end
      end
   endtask

   task automatic test_start_held();
      logic [63:0] pt;
      int lat, el, dones, extra;
      el = (CACHE_EN && cache_vld && (VEC_KEY[2] == cache_key)) ? 32 : 63;
      @(negedge clk);
      key = VEC_KEY[2]; ctext = VEC_CT[2]; start = 1'b1;
      @(posedge clk);
      #1;
      key = VEC_KEY[3]; ctext = VEC_CT[3];
      lat = -1; pt = 'x; dones = 0;
      for (int c = 0; c < MAX_WAIT; c++) begin
         @(negedge clk);
         if (done) begin
            dones++; lat = c; pt = ptext; start = 1'b0;
            break;
         end
      end
      cache_vld = 1'b1; cache_key = VEC_KEY[2];
      extra = 0;
      repeat (80) begin
         @(negedge clk);
         if (done) extra++;
      end
      n_checks++;
      if (pt !== VEC_PT[2]) begin n_fail++; $display("FAIL held_ptext: got %h want %h", pt, VEC_PT[2]); end
      n_checks++;
      if (lat != el) begin n_fail++; $display("FAIL held_latency: got %0d want %0d", lat, el); end
      n_checks++;
      if (dones + extra != 1) begin n_fail++; $display("FAIL held_done_count: got %0d want 1", dones + extra); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL held_busy_idle: got %b want 0", busy); end
   endtask

   task automatic test_reset_abort();
      logic [63:0] pt;
      int lat, el, bb, dones;
      @(negedge clk);
      key = VEC_KEY[0]; ctext = VEC_CT[0]; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      dones = 0;
      repeat (41) begin
         @(negedge clk);
         if (done) dones++;
      end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b want 1", busy); end
      rst = 1'b1;
      cache_vld = 1'b0;
      #1;
      n_checks++;
      if (ptext !== 64'h0) begin n_fail++; $display("FAIL abort_ptext: got %h want %h", ptext, 64'h0); end
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL abort_flags: got busy=%b done=%b want 0 0", busy, done);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (done) dones++;
      end
      n_checks++;
      if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d dones want 0", dones); end
      run_op(VEC_KEY[0], VEC_CT[0], pt, lat, el, bb);
      n_checks++;
      if (pt !== VEC_PT[0]) begin n_fail++; $display("FAIL abort_restart_ptext: got %h want %h", pt, VEC_PT[0]); end
      n_checks++;
      if (lat != el) begin n_fail++; $display("FAIL abort_restart_latency: got %0d want %0d", lat, el); end
   endtask

   initial begin
      test_reset();
      test_known_vectors();
      test_back_to_back();
      test_key_cache();
      test_random();
      test_start_held();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
